// File: rtl/w_mem_loader_if.sv
// w_mem_loader_if: weight stream input plus shared write port to a layer's weight memories.
interface w_mem_loader_if #(
  parameter int numNeuron    = 30,
  parameter int numWeight    = 30,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight)
);
  logic                    start;
  logic                    abort;
  logic                    s_valid;
  logic [dataWidth-1:0]    s_data;
  logic                    s_ready;
  logic [numNeuron-1:0]    mem_wen;
  logic [addressWidth-1:0] mem_wadd;
  logic [dataWidth-1:0]    mem_win;
  logic                    busy;
  logic                    done;
  modport master (output start, abort, s_valid, s_data,
                  input  s_ready, mem_wen, mem_wadd, mem_win, busy, done);
  modport slave  (input  start, abort, s_valid, s_data,
                  output s_ready, mem_wen, mem_wadd, mem_win, busy, done);
endinterface

// File: rtl/w_mem_loader.sv
// w_mem_loader: demultiplexes a weight stream, neuron-major, into one layer's bank of weight memories.
module w_mem_loader #(
  parameter int numNeuron    = 30,
  parameter int numWeight    = 30,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight),
  parameter int neuronWidth  = $clog2(numNeuron)
) (
  input logic clk,
  input logic rst_n,
  w_mem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t                  state;
  logic [addressWidth-1:0] weight_cnt;
  logic [neuronWidth-1:0]  neuron_cnt;
  logic                    fire;
  logic                    last_w;
  logic                    last;
  assign fire   = bus.s_valid && bus.s_ready;
  assign last_w = weight_cnt == addressWidth'(numWeight - 1);
  assign last   = last_w && neuron_cnt == neuronWidth'(numNeuron - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      weight_cnt  <= '0;
      neuron_cnt  <= '0;
      bus.s_ready <= 1'b0;
      bus.mem_wen <= '0;
      bus.mem_wadd <= '0;
      bus.mem_win <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.mem_wen <= '0;
      case (state)
        IDLE: if (bus.start) begin
          state       <= LOAD;
          weight_cnt  <= '0;
          neuron_cnt  <= '0;
          bus.s_ready <= 1'b1;
          bus.busy    <= 1'b1;
          bus.done    <= 1'b0;
        end
        LOAD: if (bus.abort) begin
          // abort wins over a beat offered in the same cycle; that beat is never written
          state       <= IDLE;
          weight_cnt  <= '0;
          neuron_cnt  <= '0;
          bus.s_ready <= 1'b0;
          bus.busy    <= 1'b0;
        end else if (fire) begin
          bus.mem_wen  <= numNeuron'(1) << neuron_cnt;
          bus.mem_wadd <= weight_cnt;
          bus.mem_win  <= dataWidth'(bus.s_data);
          weight_cnt   <= last_w ? '0 : weight_cnt + 1'b1;
          neuron_cnt   <= last ? '0 : neuron_cnt + neuronWidth'(last_w);
          if (last) begin
            state       <= DONE;
            bus.s_ready <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_w_mem_loader.sv
// tb_w_mem_loader: directed loads against a modelled bank of 30 weight memories.
module tb_w_mem_loader;
  localparam int NN = 30;
  localparam int NW = 30;
  localparam int NB = NN * NW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] mm [NN][NW];
  always #5 clk = ~clk;
  w_mem_loader_if bus ();
  w_mem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memories capture strobes mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (bus.mem_wen != '0) check("onehot", 64'($countones(bus.mem_wen)), 64'd1);
    for (int n = 0; n < NN; n++) if (bus.mem_wen[n]) mm[n][bus.mem_wadd] = bus.mem_win;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input bit gaps, input bit poke);
    int i = 0;
    int n = 0;
    int stalls = 0;
    int bad = 0;
    logic v;
    for (int a = 0; a < NN; a++) for (int b = 0; b < NW; b++) mm[a][b] = 16'hdead;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("busy_start", 64'(bus.busy), 64'd1);
    check("done_clr", 64'(bus.done), 64'd0);
    check("ready_load", 64'(bus.s_ready), 64'd1);
    while (i < NB && n < 4 * NB) begin
      v = gaps ? 1'($urandom_range(1)) : 1'b1;
      bus.s_valid = v;
      bus.s_data = 16'(base + i);
      bus.start = poke && i == 100 && v;
      cyc();
      n++;
      if (v) begin
        check("beat", {bus.mem_wen, bus.mem_wadd, bus.mem_win},
              {30'(1) << (i / NW), 5'(i % NW), 16'(base + i)});
        if (i == 0) check("b0_wadd_win", {bus.mem_wen, bus.mem_wadd, bus.mem_win}, {30'h1, 5'd0, 16'(base)});
        if (i == 31) check("b31", {bus.mem_wen, bus.mem_wadd, bus.mem_win}, {30'h2, 5'd1, 16'(base + 31)});
        if (i == 899) check("b899", {bus.mem_wen, bus.mem_wadd, bus.mem_win}, {30'h2000_0000, 5'd29, 16'(base + 899)});
        if (poke && i == 101) check("start_ignored_b101", {bus.mem_wen, bus.mem_wadd}, {30'h8, 5'd11});
        i++;
      end else if (bus.mem_wen != '0) stalls++;
    end
    bus.s_valid = 1'b0;
    bus.start = 1'b0;
    check("beats", 64'(i), 64'(NB));
    check("stall_strobes", 64'(stalls), 64'd0);
    if (gaps) check("gap_slow", 64'(n > NB), 64'd1);
    cyc();
    check("done_set", 64'(bus.done), 64'd1);
    check("busy_end", 64'(bus.busy), 64'd0);
    check("ready_end", 64'(bus.s_ready), 64'd0);
    check("wen_end", 64'(bus.mem_wen), 64'd0);
    cyc();
    for (int a = 0; a < NN; a++)
      for (int b = 0; b < NW; b++) if (mm[a][b] !== 16'(base + a * NW + b)) bad++;
    check("mem_contents", 64'(bad), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (2) cyc();
    check("rst_outs", {bus.mem_wen, bus.mem_wadd, bus.mem_win, bus.busy, bus.done, bus.s_ready}, 64'd0);
    rst_n = 1'b1;
    cyc();
    check("idle_ready", 64'(bus.s_ready), 64'd0);
    load(0, 1'b0, 1'b0);
    load(1000, 1'b1, 1'b0);
    load(2000, 1'b0, 1'b1);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 16'(i);
      cyc();
    end
    bus.s_data = 16'd45;
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.s_valid = 1'b0;
    check("abort_wen", 64'(bus.mem_wen), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_ready", 64'(bus.s_ready), 64'd0);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort_idle_noop", {bus.mem_wen, bus.busy, bus.done}, 64'd0);
    load(5000, 1'b0, 1'b0);
    load(7000, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 16'(16'h100 + i);
      cyc();
    end
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst", {bus.mem_wen, bus.mem_wadd, bus.mem_win, bus.busy, bus.done, bus.s_ready}, 64'd0);
    #2;
    rst_n = 1'b1;
    cyc();
    check("post_rst", {bus.s_ready, bus.busy, bus.mem_wen}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
